debug_device: RTL and testbench
===============================

# debug_device

Membus responder for the debug window: the device behind the MMIO controller's debug master port, decoding offsets 0–7 of the debug region. Holds a sticky test-termination register (TOHOST) for simulation/bring-up exit. Holds a console register whose byte writes are buffered in a small FIFO and streamed out on a valid/ready character port to a testbench printer or UART.

## Interface
- FIFO_DEPTH, 8, console FIFO entries; power of two, ≥2
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- membus  Membus.slave  —  request/response port; addr is the offset inside the debug window
- test_done  out  1  sticky; TOHOST written with bit0=1
- test_code  out  31  wdata[31:1] captured with test_done
- char_valid  out  1  console byte available
- char_data  out  8  console byte, FIFO head
- char_ready  in  1  consumer accepts byte when char_valid && char_ready

## Operation
- Decode uses addr[2] only; addr[1:0] and upper bits ignored.
  - addr[2]=0 → TOHOST.
  - addr[2]=1 → CONSOLE.
- Data is LSB-aligned in wdata/rdata.
- Upper rdata bits beyond 31 are zero.
- Accept: membus.valid && membus.ready. Reads and writes are both accepted this way.
- Every accepted request gets exactly one rvalid pulse.
- TOHOST write: takes effect only if wmask[0]=1 and wdata[0]=1 and test_done=0.
  - Sets test_done=1 and test_code=wdata[31:1].
  - Later writes are ignored until reset.
- TOHOST read: rdata={test_code, test_done}.
- CONSOLE write with wmask[0]=1: pushes wdata[7:0] into the FIFO.
- CONSOLE write with wmask[0]=0: completes with rvalid, no push.
- CONSOLE read: rdata[0]=empty, rdata[1]=full, rdata[15:8]=count, other bits 0.
- ready = !rvalid_q && !fifo_full.
  - Low during the response cycle, so a master that holds valid until it sees rvalid is never double-accepted.
  - Low while the FIFO is full; this stalls all offsets. A held request is accepted in the cycle after a pop frees a slot.
- FIFO:
  - char_valid = count≠0; char_data = entry at the read pointer.
  - Pop on char_valid && char_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH+1).
- Read data reflects state before the accepting edge. A CONSOLE status read reports count before any same-cycle push or pop.

## Timing
- Response latency: rvalid exactly 1 cycle after acceptance, for 1 cycle. rdata is valid in that cycle and 0 otherwise.
- Maximum throughput: one request every 2 cycles.
- Console write accepted at edge T:
  - byte visible on char_data/char_valid after T+1;
  - its rvalid is also in cycle T+1.
- test_done/test_code update at the accepting edge and are visible in the same cycle as rvalid.
- Reset values (async, rst=0):
  - rvalid=0, rdata=0, ready=1 once rst releases;
  - test_done=0, test_code=0;
  - FIFO empty: char_valid=0, char_data=0, pointers=0.
- Reset mid-operation: a pending response and buffered bytes are discarded; no rvalid is issued for the aborted request.

## Configuration
- DBG_CONSOLE_EN defined: console FIFO and character port present, as above.
- DBG_CONSOLE_EN undefined:
  - no FIFO; char_valid=0 and char_data=0 permanently;
  - CONSOLE writes complete with rvalid and are discarded;
  - CONSOLE reads return empty=1, all other bits 0;
  - ready = !rvalid_q.

## Structure
- Shared package eei holds:
  - DBG_REG_TOHOST=0 and DBG_REG_CONSOLE=4 (byte offsets);
  - DBG_STAT_EMPTY_BIT=0, DBG_STAT_FULL_BIT=1;
  - typedef DbgReg (enum TOHOST/CONSOLE) for decode.
- Sub-module dbg_char_fifo:
  - synchronous 8-bit FIFO, parameter DEPTH;
  - ports push/pdata/full, pop/head/empty, count;
  - instantiated only under DBG_CONSOLE_EN.

## Test plan
- Reset, then read offset 0 → rvalid one cycle after accept, rdata=0. Read offset 4 → rdata=0x1 (empty). ready low only in the rvalid cycle.
- Write offset 0, wdata=0x0000_0015, wmask=0xF → test_done=1, test_code=0xA. A following write of 0x0000_0007 leaves test_code=0xA.
- Master holds valid high through the rvalid cycle for a console write of 0x41 → exactly one byte 0x41 emerges; no duplicate push.
- char_ready=0, write 8 bytes 0x30..0x37 → full; status read is not yet possible because ready=0. A 9th write stalls until char_ready=1 for one cycle, then is accepted the next cycle. Order out is 0x30..0x38.
- Simultaneous pop and push at count=3 → count stays 3, data order preserved across pointer wrap.
- Assert rst mid-response with 4 bytes buffered → all outputs return to reset values, no rvalid; after release, status reads 0x1.

Source files
------------

// File: rtl/eei.sv
// Shared definitions for the debug window: register offsets, status bit positions and decode type.
package eei;

  localparam int MEMBUS_ADDR_W = 32;
  localparam int MEMBUS_DATA_W = 64;

  localparam logic [MEMBUS_ADDR_W-1:0] DBG_REG_TOHOST  = 'h0;
  localparam logic [MEMBUS_ADDR_W-1:0] DBG_REG_CONSOLE = 'h4;

  localparam int DBG_STAT_EMPTY_BIT = 0;
  localparam int DBG_STAT_FULL_BIT  = 1;
  localparam int DBG_STAT_COUNT_LSB = 8;

  typedef enum logic {
    TOHOST  = 1'b0,
    CONSOLE = 1'b1
  } DbgReg;

  // Only address bit 2 distinguishes the two registers inside the window.
  function automatic DbgReg decodeReg(input logic addrBit2);
    return (addrBit2 == DBG_REG_CONSOLE[2]) ? CONSOLE : TOHOST;
  endfunction

endpackage

// File: rtl/dbg_char_fifo.sv
// Single-clock byte FIFO buffering console characters; DEPTH must be a power of two.
module dbg_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [7:0]                   pdata_i,
  output logic                         full_o,
  input  logic                         pop_i,
  output logic [7:0]                   head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PtrW   = $clog2(DEPTH);
  localparam int CountW = $clog2(DEPTH + 1);

  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [CountW-1:0] count_q;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == CountW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wptr_q] <= pdata_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (doPop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/debug_device.sv
// Debug-window membus responder: sticky TOHOST exit register plus console byte stream.
// Define DBG_CONSOLE_EN to build the console FIFO and character port; otherwise console writes are dropped.
module debug_device
  import eei::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     membus_valid_i,
  output logic                     membus_ready_o,
  input  logic [MEMBUS_ADDR_W-1:0] membus_addr_i,
  input  logic                     membus_wen_i,
  input  logic [MEMBUS_DATA_W-1:0] membus_wdata_i,
  input  logic [MEMBUS_DATA_W/8-1:0] membus_wmask_i,
  output logic                     membus_rvalid_o,
  output logic [MEMBUS_DATA_W-1:0] membus_rdata_o,
  output logic                     test_done_o,
  output logic [30:0]              test_code_o,
  output logic                     char_valid_o,
  output logic [7:0]               char_data_o,
  input  logic                     char_ready_i
);

  localparam int CountW = $clog2(FIFO_DEPTH + 1);

  logic                     rvalid_q;
  logic [MEMBUS_DATA_W-1:0] rdata_q;
  logic [MEMBUS_DATA_W-1:0] rdata_d;
  logic                     test_done_q;
  logic                     test_done_d;
  logic [30:0]              test_code_q;
  logic [30:0]              test_code_d;

  logic              accept;
  logic              pushReq;
  DbgReg             regSel;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CountW-1:0] fifoCount;
  logic [7:0]        fifoHead;
  logic              unusedBits;

  assign regSel          = decodeReg(membus_addr_i[2]);
  assign membus_ready_o  = !rvalid_q && !fifoFull;
  assign accept          = membus_valid_i && membus_ready_o;
  assign membus_rvalid_o = rvalid_q;
  assign membus_rdata_o  = rdata_q;
  assign test_done_o     = test_done_q;
  assign test_code_o     = test_code_q;
  assign char_valid_o    = !fifoEmpty;
  assign char_data_o     = fifoHead;

  assign unusedBits = ^{membus_addr_i[MEMBUS_ADDR_W-1:3], membus_addr_i[1:0],
                        membus_wdata_i[MEMBUS_DATA_W-1:32], membus_wmask_i[MEMBUS_DATA_W/8-1:1]};

`ifdef DBG_CONSOLE_EN
  logic fifoPop;

  assign fifoPop = char_ready_i && !fifoEmpty;

  dbg_char_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (pushReq),
    .pdata_i(membus_wdata_i[7:0]),
    .full_o (fifoFull),
    .pop_i  (fifoPop),
    .head_o (fifoHead),
    .empty_o(fifoEmpty),
    .count_o(fifoCount)
  );
`else
  logic unusedConsole;

  assign fifoFull      = 1'b0;
  assign fifoEmpty     = 1'b1;
  assign fifoCount     = '0;
  assign fifoHead      = '0;
  assign unusedConsole = ^{char_ready_i, pushReq};
`endif

  // Read data is built from pre-edge state, so a status read never sees its own cycle's push or pop.
  always_comb begin
    rdata_d     = '0;
    test_done_d = test_done_q;
    test_code_d = test_code_q;
    pushReq     = 1'b0;
    if (accept) begin
      case (regSel)
        TOHOST: begin
          if (membus_wen_i) begin
            if (membus_wmask_i[0] && membus_wdata_i[0] && !test_done_q) begin
              test_done_d = 1'b1;
              test_code_d = membus_wdata_i[31:1];
            end
          end else begin
            rdata_d[31:0] = {test_code_q, test_done_q};
          end
        end
        CONSOLE: begin
          if (membus_wen_i) begin
            pushReq = membus_wmask_i[0];
          end else begin
            rdata_d[DBG_STAT_EMPTY_BIT]       = fifoEmpty;
            rdata_d[DBG_STAT_FULL_BIT]        = fifoFull;
            rdata_d[DBG_STAT_COUNT_LSB +: 8]  = 8'(fifoCount);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      test_done_q <= 1'b0;
      test_code_q <= '0;
    end else begin
      rvalid_q    <= accept;
      rdata_q     <= rdata_d;
      test_done_q <= test_done_d;
      test_code_q <= test_code_d;
    end
  end

endmodule

// File: tb/tb_debug_device.sv
// Bench for debug_device: register vectors, console streaming (when DBG_CONSOLE_EN) and mid-response reset.
module tb_debug_device;
  import eei::*;

  logic        clk;
  logic        rst_n;
  logic        membusValid;
  logic        membusReady;
  logic [31:0] membusAddr;
  logic        membusWen;
  logic [63:0] membusWdata;
  logic [7:0]  membusWmask;
  logic        membusRvalid;
  logic [63:0] membusRdata;
  logic        testDone;
  logic [30:0] testCode;
  logic        charValid;
  logic [7:0]  charData;
  logic        charReady;

  int checks = 0;
  int errors = 0;

  logic [63:0] expQ[$];
  logic [7:0]  charQ[$];
  logic [63:0] expRd;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] expRdata;
    logic        expDone;
    logic [30:0] expCode;
  } vec_t;

  vec_t vecs[12];

  debug_device #(
    .FIFO_DEPTH(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .membus_valid_i (membusValid),
    .membus_ready_o (membusReady),
    .membus_addr_i  (membusAddr),
    .membus_wen_i   (membusWen),
    .membus_wdata_i (membusWdata),
    .membus_wmask_i (membusWmask),
    .membus_rvalid_o(membusRvalid),
    .membus_rdata_o (membusRdata),
    .test_done_o    (testDone),
    .test_code_o    (testCode),
    .char_valid_o   (charValid),
    .char_data_o    (charData),
    .char_ready_i   (charReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one request from a negedge, waits for ready, and returns at the negedge of the response cycle
  // (or one cycle later when the master keeps valid asserted through the response).
  task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wmask, input logic [63:0] expRdata,
                               input logic holdValid, input logic popAtAccept);
    int waited;
    waited = 0;
    expQ.push_back(expRdata);
    membusValid = 1'b1;
    membusWen   = wen;
    membusAddr  = addr;
    membusWdata = wdata;
    membusWmask = wmask;
    while (!membusReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!membusReady) begin
      checkOutput("accept timeout", membusReady, 1);
      expQ.delete(expQ.size() - 1);
      membusValid = 1'b0;
      return;
    end
    if (popAtAccept) charReady = 1'b1;
    @(negedge clk);
    if (popAtAccept) charReady = 1'b0;
    checkOutput("rvalid latency", membusRvalid, 1);
    checkOutput("ready in response cycle", membusReady, 0);
    if (holdValid) @(negedge clk);
    membusValid = 1'b0;
    membusWen   = 1'b0;
  endtask

  task automatic consoleWrite(input logic [7:0] ch, input logic popAtAccept);
`ifdef DBG_CONSOLE_EN
    charQ.push_back(ch);
`endif
    applyStimulus(1'b1, DBG_REG_CONSOLE, {56'h0, ch}, 8'h01, 64'h0, 1'b0, popAtAccept);
  endtask

  task automatic drainChars();
    charReady = 1'b1;
    for (int i = 0; i < 40 && charQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    charReady = 1'b0;
    checkOutput("drain", charQ.size(), 0);
  endtask

  // Response and character scoreboards, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (membusRvalid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious rvalid", membusRvalid, 0);
        end else begin
          expRd = expQ.pop_front();
          checkOutput("rdata", membusRdata, expRd);
        end
      end else begin
        checkOutput("rdata idle", membusRdata, 0);
      end
`ifdef DBG_CONSOLE_EN
      if (charValid && charReady) begin
        if (charQ.size() == 0) checkOutput("spurious char", charValid, 0);
        else checkOutput("char order", charData, charQ.pop_front());
      end
`else
      checkOutput("char port off", {charValid, charData}, 0);
`endif
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0,         64'h0,  8'h00, 64'h0,  1'b0, 31'h0};
    vecs[1]  = '{1'b0, 32'h4,         64'h0,  8'h00, 64'h1,  1'b0, 31'h0};
    vecs[2]  = '{1'b0, 32'h7,         64'h0,  8'h00, 64'h1,  1'b0, 31'h0};
    vecs[3]  = '{1'b0, 32'h1000_0003, 64'h0,  8'h00, 64'h0,  1'b0, 31'h0};
    vecs[4]  = '{1'b1, 32'h0,         64'h14, 8'h0F, 64'h0,  1'b0, 31'h0};
    vecs[5]  = '{1'b1, 32'h0,         64'h15, 8'hFE, 64'h0,  1'b0, 31'h0};
    vecs[6]  = '{1'b1, 32'h0,         64'hFFFF_FFFF_0000_0015, 8'h0F, 64'h0, 1'b1, 31'hA};
    vecs[7]  = '{1'b1, 32'h0,         64'h7,  8'h0F, 64'h0,  1'b1, 31'hA};
    vecs[8]  = '{1'b0, 32'h0,         64'h0,  8'h00, 64'h15, 1'b1, 31'hA};
    vecs[9]  = '{1'b1, 32'h4,         64'h41, 8'hFE, 64'h0,  1'b1, 31'hA};
    vecs[10] = '{1'b0, 32'h4,         64'h0,  8'h00, 64'h1,  1'b1, 31'hA};
    vecs[11] = '{1'b0, 32'h3,         64'h0,  8'h00, 64'h15, 1'b1, 31'hA};

    rst_n       = 1'b0;
    membusValid = 1'b0;
    membusWen   = 1'b0;
    membusAddr  = '0;
    membusWdata = '0;
    membusWmask = '0;
    charReady   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset rvalid", membusRvalid, 0);
    checkOutput("reset rdata", membusRdata, 0);
    checkOutput("reset test_done", testDone, 0);
    checkOutput("reset test_code", testCode, 0);
    checkOutput("reset char_valid", charValid, 0);
    checkOutput("reset char_data", charData, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset ready", membusReady, 1);
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].expRdata, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d test_done", i), testDone, vecs[i].expDone);
      checkOutput($sformatf("vec%0d test_code", i), testCode, vecs[i].expCode);
    end
    @(negedge clk);
    checkOutput("ready idle", membusReady, 1);

`ifdef DBG_CONSOLE_EN
    // Master holds valid through the response: exactly one byte must come out.
    charReady = 1'b1;
    charQ.push_back(8'h41);
    applyStimulus(1'b1, DBG_REG_CONSOLE, 64'h41, 8'h01, 64'h0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("no duplicate push", charValid, 0);
    charReady = 1'b0;

    // Fill to full, then a ninth write stalls until a single pop frees a slot.
    for (int i = 0; i < 8; i++) begin
      consoleWrite(8'(8'h30 + i), 1'b0);
      if (i == 0) begin
        checkOutput("char_valid after write", charValid, 1);
        checkOutput("char_data after write", charData, 8'h30);
      end
    end
    @(negedge clk);
    checkOutput("ready while full", membusReady, 0);
    fork
      consoleWrite(8'h38, 1'b0);
      begin
        repeat (3) @(negedge clk);
        charReady = 1'b1;
        @(negedge clk);
        charReady = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("ready full again", membusReady, 0);
    drainChars();
    applyStimulus(1'b0, DBG_REG_CONSOLE, 64'h0, 8'h00, 64'h1, 1'b0, 1'b0);

    // Advance pointers so the next three bytes straddle the wrap point.
    charReady = 1'b1;
    for (int i = 0; i < 5; i++) consoleWrite(8'(8'h60 + i), 1'b0);
    drainChars();
    for (int i = 0; i < 3; i++) consoleWrite(8'(8'h50 + i), 1'b0);
    applyStimulus(1'b0, DBG_REG_CONSOLE, 64'h0, 8'h00, 64'h300, 1'b0, 1'b0);
    consoleWrite(8'h53, 1'b1);
    applyStimulus(1'b0, DBG_REG_CONSOLE, 64'h0, 8'h00, 64'h300, 1'b0, 1'b0);
    drainChars();
    applyStimulus(1'b0, DBG_REG_CONSOLE, 64'h0, 8'h00, 64'h1, 1'b0, 1'b0);
`else
    consoleWrite(8'h41, 1'b0);
    applyStimulus(1'b0, DBG_REG_CONSOLE, 64'h0, 8'h00, 64'h1, 1'b0, 1'b0);
    checkOutput("console disabled char_valid", charValid, 0);
`endif

    // Reset lands in the response cycle of a read with bytes still buffered.
    for (int i = 0; i < 4; i++) consoleWrite(8'(8'h70 + i), 1'b0);
    @(negedge clk);
    membusValid = 1'b1;
    membusWen   = 1'b0;
    membusAddr  = DBG_REG_TOHOST;
    @(posedge clk);
    #1;
    checkOutput("rvalid before abort", membusRvalid, 1);
    rst_n       = 1'b0;
    membusValid = 1'b0;
    #1;
    checkOutput("abort rvalid", membusRvalid, 0);
    checkOutput("abort rdata", membusRdata, 0);
    checkOutput("abort test_done", testDone, 0);
    checkOutput("abort test_code", testCode, 0);
    checkOutput("abort char_valid", charValid, 0);
    checkOutput("abort char_data", charData, 0);
    charQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready after reset", membusReady, 1);
    @(negedge clk);
    applyStimulus(1'b0, DBG_REG_CONSOLE, 64'h0, 8'h00, 64'h1, 1'b0, 1'b0);
    applyStimulus(1'b0, DBG_REG_TOHOST, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pending responses", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
